playback_sequencer: RTL
=======================

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 Parameter BEAT_CYCLES, default 12_500_000, clk cycles per beat at tempo_sel=0.
REQ-002 Parameter GAP_CYCLES, default 1_250_000, silent cycles at the end of each beat.
REQ-003 Parameter SETTLE_CYCLES, default 2, cycles sound_en stays low after note_counter changes; covers the address register plus synchronous memory read.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request: begin playback at slot 0.
REQ-007 stop  input  1  one-cycle request: abort playback.
REQ-008 loop  input  1  level; when high, playback wraps to slot 0 after the last note.
REQ-009 note_count  input  5  number of recorded notes, 0..16; values above 16 are treated as 16.
REQ-010 tempo_sel  input  2  beat length = BEAT_CYCLES >> tempo_sel.
REQ-011 ld_play  output  1  high in every non-IDLE state; drives the datapath play-load input.
REQ-012 note_counter  output  4  memory slot currently being played.
REQ-013 sound_en  output  1  gates the tone output; high only in the audible part of a note.
REQ-014 busy  output  1  high in every non-IDLE state.
REQ-015 done  output  1  one-cycle pulse when playback completes normally.

Function
REQ-016 The sequencer SHALL have three states: IDLE, NOTE and GAP.
REQ-017 The sequencer SHALL use a 32-bit down-counter, cnt, for state timing.
REQ-018 IDLE, start=1, stop=0, effective count N>0: next state NOTE, note_counter=0, cnt=(BEAT_CYCLES>>tempo_sel)-GAP_CYCLES-1.
REQ-019 IDLE, start=1, stop=0, N=0: the sequencer SHALL stay IDLE and pulse done on the next cycle.
REQ-020 NOTE: cnt decrements each cycle; when cnt==0, next state GAP with cnt=GAP_CYCLES-1.
REQ-021 sound_en SHALL be high only in NOTE, and only from the (SETTLE_CYCLES+1)th cycle of that NOTE; it is low in GAP and IDLE.
REQ-022 GAP, cnt==0, note_counter<N-1: the sequencer SHALL increment note_counter, enter NOTE and reload cnt using tempo_sel sampled in that cycle.
REQ-023 GAP, cnt==0, note_counter==N-1, loop=1: note_counter SHALL wrap to 0 and the sequencer SHALL enter NOTE with no done pulse.
REQ-024 GAP, cnt==0, note_counter==N-1, loop=0: next state IDLE, done=1 for exactly that one cycle.
REQ-025 stop=1 in any state SHALL force IDLE on the next edge, with no done pulse; stop has priority over start in the same cycle.
REQ-026 start=1 while busy and stop=0 SHALL restart at slot 0 exactly as in REQ-018.
REQ-027 N SHALL be sampled at start and at every note transition; if a reduced N gives note_counter>=N-1, the current note is treated as the last.
REQ-028 note_counter SHALL hold its value in IDLE.
REQ-029 The design requires (BEAT_CYCLES>>3) > GAP_CYCLES+SETTLE_CYCLES+1; this is checked by an elaboration-time assertion.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While reset=1: state=IDLE, note_counter=0, cnt=0, and ld_play, sound_en, busy and done all 0, independent of clk.
REQ-032 After reset deasserts, the sequencer SHALL ignore start until the first rising edge; a reset asserted mid-note SHALL clear sound_en immediately.

Verification (BEAT_CYCLES=64, GAP_CYCLES=4, SETTLE_CYCLES=2)
REQ-033 N=3, tempo_sel=0, loop=0, pulse start -> note_counter 0,1,2 in turn, each NOTE 60 cycles with sound_en high for 58, each GAP 4 cycles; done pulses once, 192 cycles after the start edge; busy then falls.
REQ-034 N=2, loop=1, pulse start -> note_counter sequence 0,1,0,1,... with no done pulse; stop at cycle 150 -> IDLE, busy=0, sound_en=0 on the next edge.
REQ-035 N=0, pulse start -> done high for exactly one cycle; busy, ld_play and sound_en stay 0.
REQ-036 tempo_sel=3 (beat of 8 cycles), N=16, loop=0 -> each NOTE 4 cycles and each GAP 4 cycles; note_counter reaches 15 and then done pulses; note_count=20 behaves identically.
REQ-037 start and stop high in the same cycle during slot 5 -> IDLE, note_counter holds 5, no done pulse.
REQ-038 Reset asserted asynchronously between edges mid-NOTE -> all outputs 0 before the next edge; start after release plays slot 0.

Source files
------------

// File: rtl/playback_sequencer.sv
// Note playback sequencer.
// Steps through recorded note slots. Each slot gets one beat: an audible
// NOTE part followed by a silent GAP. The beat length is set by tempo_sel.
// sound_en stays low for the first SETTLE_CYCLES of every note. This gives the
// slot address and the synchronous memory read time to settle.
module playback_sequencer #(
  parameter int unsigned BEAT_CYCLES   = 12_500_000,
  parameter int unsigned GAP_CYCLES    = 1_250_000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [4:0] note_count,
  input  logic [1:0] tempo_sel,
  output logic       ld_play,
  output logic [3:0] note_counter,
  output logic       sound_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned   SW         = $clog2(SETTLE_CYCLES + 1) + 1;
  localparam logic [SW-1:0] SETTLE_LIM = SW'(SETTLE_CYCLES);
  localparam logic [31:0]   BEAT_W     = 32'(BEAT_CYCLES);
  localparam logic [31:0]   GAP_W      = 32'(GAP_CYCLES);

  // The fastest tempo must still leave an audible part after the gap and settle time.
  if ((BEAT_CYCLES >> 3) <= GAP_CYCLES + SETTLE_CYCLES + 1) begin : g_bad_timing
    $error("playback_sequencer: BEAT_CYCLES>>3 must exceed GAP_CYCLES+SETTLE_CYCLES+1");
  end

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    note_counter_d;
  logic          done_d;
  logic          note_entry;
  logic [4:0]    n_eff;
  logic          last_note;
  logic [31:0]   reload_val;

  // Note count is clamped to 16. Audible length of a new note comes from the current tempo_sel.
  always_comb begin : derive_limits
    n_eff      = (note_count > 5'd16) ? 5'd16 : note_count;
    last_note  = (({1'b0, note_counter} + 5'd1) >= n_eff);
    reload_val = (BEAT_W >> tempo_sel) - GAP_W - 32'd1;
  end

  // Next-state, timing counter and slot selection; stop beats start, start beats timing.
  always_comb begin : next_state_logic
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    cnt_d          = cnt_q;
    note_counter_d = note_counter;
    done_d         = 1'b0;
    note_entry     = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      if (n_eff != 5'd0) begin
        state_d        = NOTE;
        note_counter_d = 4'd0;
        cnt_d          = reload_val;
        note_entry     = 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        NOTE: begin
          if (cnt_q == 32'd0) begin
            state_d = GAP;
            cnt_d   = GAP_W - 32'd1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        GAP: begin
          if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
          end else if (!last_note) begin
            state_d        = NOTE;
            note_counter_d = note_counter + 4'd1;
            cnt_d          = reload_val;
            note_entry     = 1'b1;
          end else if (loop && (n_eff != 5'd0)) begin
            state_d        = NOTE;
            note_counter_d = 4'd0;
            cnt_d          = reload_val;
            note_entry     = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (note_entry) begin
      settle_d = '0;
    end else if ((state_q == NOTE) && (settle_q < SETTLE_LIM)) begin
      settle_d = settle_q + SW'(1);
    end else begin
      settle_d = settle_q;
    end
  end

  // State, timing counter, settle counter and slot registers.
  always_ff @(posedge clk or posedge reset) begin : state_regs
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      settle_q     <= '0;
      note_counter <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      note_counter <= note_counter_d;
    end
  end

  // Registered status outputs are decoded from next-state values, so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin : output_regs
    if (reset) begin
      busy     <= 1'b0;
      ld_play  <= 1'b0;
      sound_en <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy     <= (state_d != IDLE);
      ld_play  <= (state_d != IDLE);
      sound_en <= (state_d == NOTE) && (settle_d >= SETTLE_LIM);
      done     <= done_d;
    end
  end

endmodule
